// File: rtl/tdes_pkg.sv
// Shared Triple-DES definitions: permutation and S-box tables, key shift schedules,
// mode encodings, controller state type and the small permutation helpers.
package tdes_pkg;

    localparam logic ENC = 1'b0;
    localparam logic DEC = 1'b1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // All tables use the 1-based DES bit numbering, bit 1 = MSB.
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Indexed by {row, col} = {b5, b0, b4..b1} of the 6-bit group.
    localparam int SBOX [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

    localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    function automatic bit rpc_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16);
    endfunction

    function automatic logic [63:0] perm_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_e(input logic [31:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rot_cd(input logic [27:0] v, input logic [1:0] amt,
                                           input logic right);
        logic [27:0] y;
        y = v;
        if (amt == 2'd1) y = right ? {v[0], v[27:1]} : {v[26:0], v[27]};
        if (amt == 2'd2) y = right ? {v[1:0], v[27:2]} : {v[25:0], v[27:26]};
        return y;
    endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: (L, R, K) -> (R, L ^ f(R, K)).
module des_round
    import tdes_pkg::*;
(
    input  logic [31:0] l,
    input  logic [31:0] r,
    input  logic [47:0] subkey,
    output logic [31:0] l_next,
    output logic [31:0] r_next
);

    logic [47:0] mixed;
    logic [31:0] s_out;

    always_comb begin
        s_out = '0;
        mixed = perm_e(r) ^ subkey;
        for (int j = 0; j < 8; j++) begin
            logic [5:0] grp;
            grp = mixed[47-6*j -: 6];
            s_out[31-4*j -: 4] = 4'(SBOX[j][{grp[5], grp[0], grp[4:1]}]);
        end
    end

    assign l_next = r;
    assign r_next = l ^ perm_p(s_out);

endmodule

// File: rtl/tdes_iter.sv
// Iterative Triple-DES (EDE) engine, ROUNDS_PER_CYCLE Feistel rounds per clock.
// Optional CBC chaining is compiled in with the TDES_ITER_CBC_EN macro.
//
// state | meaning
// IDLE  | accept_o high, waiting for valid_i
// RUN   | applying rounds over the three stages
// DONE  | result held on data_o until ready_i
module tdes_iter
    import tdes_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        mode_i,
    input  logic [0:63] key1_i,
    input  logic [0:63] key2_i,
    input  logic [0:63] key3_i,
    input  logic [0:63] data_i,
    input  logic        valid_i,
    output logic        accept_o,
    output logic [0:63] data_o,
    output logic        valid_o,
    input  logic        ready_i
`ifdef TDES_ITER_CBC_EN
    ,
    input  logic [0:63] iv_i,
    input  logic        iv_load_i
`endif
);

    localparam int RPC = ROUNDS_PER_CYCLE;
    localparam logic [5:0] CNT_LAST = 6'(48 / RPC - 1);

    if (!rpc_legal(ROUNDS_PER_CYCLE)) begin : g_rpc_bad
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_t      state;
    logic        mode_q;
    logic [63:0] k1_q, k2_q, k3_q;
    logic [31:0] l_q, r_q;
    logic [27:0] c_q, d_q;
    logic [5:0]  cnt;

    logic [5:0]  rnd_pos;
    logic [1:0]  stage;
    logic [3:0]  rnd_base;
    logic        st_dec, stage_end, last;
    logic [63:0] first_key, next_key, core_in, core_out, result;
    logic [27:0] c_first, d_first, c_next, d_next;

    assign rnd_pos   = cnt * 6'(RPC);
    assign stage     = rnd_pos[5:4];
    assign rnd_base  = rnd_pos[3:0];
    assign st_dec    = (mode_q == DEC) ^ (stage == 2'd1);
    assign stage_end = ({1'b0, rnd_base} + 5'(RPC)) == 5'd16;
    assign last      = (cnt == CNT_LAST);

    // Encrypt runs E(k1) D(k2) E(k3); decrypt runs D(k3) E(k2) D(k1).
    assign first_key = (mode_i == ENC) ? key1_i : key3_i;
    assign next_key  = (stage == 2'd0) ? k2_q : ((mode_q == ENC) ? k3_q : k1_q);
    assign {c_first, d_first} = perm_pc1(first_key);
    assign {c_next, d_next}   = perm_pc1(next_key);

    logic [31:0] l_ch [RPC+1];
    logic [31:0] r_ch [RPC+1];
    logic [27:0] c_ch [RPC+1];
    logic [27:0] d_ch [RPC+1];

    assign l_ch[0] = l_q;
    assign r_ch[0] = r_q;
    assign c_ch[0] = c_q;
    assign d_ch[0] = d_q;

    for (genvar k = 0; k < RPC; k++) begin : g_round
        logic [3:0]  idx;
        logic [1:0]  amt;
        logic [47:0] subkey;

        assign idx     = rnd_base + 4'(k);
        assign amt     = st_dec ? 2'(DEC_SHIFT[idx]) : 2'(ENC_SHIFT[idx]);
        assign c_ch[k+1] = rot_cd(c_ch[k], amt, st_dec);
        assign d_ch[k+1] = rot_cd(d_ch[k], amt, st_dec);
        assign subkey  = perm_pc2({c_ch[k+1], d_ch[k+1]});

        des_round u_round (
            .l      (l_ch[k]),
            .r      (r_ch[k]),
            .subkey (subkey),
            .l_next (l_ch[k+1]),
            .r_next (r_ch[k+1])
        );
    end

    assign core_out = perm_fp({r_ch[RPC], l_ch[RPC]});

`ifdef TDES_ITER_CBC_EN
    logic [63:0] chain_q, chain_eff, blk_q;

    assign chain_eff = iv_load_i ? iv_i : chain_q;
    assign core_in   = (mode_i == ENC) ? (data_i ^ chain_eff) : data_i;
    assign result    = (mode_q == DEC) ? (core_out ^ chain_q) : core_out;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            chain_q <= '0;
            blk_q   <= '0;
        end else begin
            if (state == IDLE && valid_i && accept_o) blk_q <= data_i;
            if (state == IDLE && iv_load_i)
                chain_q <= iv_i;
            else if (state == RUN && last)
                chain_q <= (mode_q == DEC) ? blk_q : result;
        end
    end
`else
    assign core_in = data_i;
    assign result  = core_out;
`endif

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state    <= IDLE;
            accept_o <= 1'b0;
            valid_o  <= 1'b0;
            data_o   <= '0;
            mode_q   <= ENC;
            k1_q     <= '0;
            k2_q     <= '0;
            k3_q     <= '0;
            l_q      <= '0;
            r_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    accept_o <= 1'b1;
                    if (valid_i && accept_o) begin
                        accept_o   <= 1'b0;
                        mode_q     <= mode_i;
                        k1_q       <= key1_i;
                        k2_q       <= key2_i;
                        k3_q       <= key3_i;
                        {l_q, r_q} <= perm_ip(core_in);
                        c_q        <= c_first;
                        d_q        <= d_first;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (last) begin
                        data_o  <= result;
                        valid_o <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        // FP then IP between stages cancels, leaving only the half swap.
                        if (stage_end) begin
                            l_q <= r_ch[RPC];
                            r_q <= l_ch[RPC];
                            c_q <= c_next;
                            d_q <= d_next;
                        end else begin
                            l_q <= l_ch[RPC];
                            r_q <= r_ch[RPC];
                            c_q <= c_ch[RPC];
                            d_q <= d_ch[RPC];
                        end
                    end
                end
                DONE: begin
                    if (valid_o && ready_i) begin
                        valid_o  <= 1'b0;
                        accept_o <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
